// File: rtl/core_reset_pkg.sv
// -----------------------------------------------------------------------------
// core_reset_pkg
// Shared types and constants for the core reset sequencer:
//   - state_e      : sequencer FSM states (HOLD, RELEASE, RUN, DRAIN)
//   - DEF_*        : default values of the sequencer parameters
//   - CNT_W        : width of the delay / timeout counters
//   - sat_dec()    : saturating decrement used by the counters
// -----------------------------------------------------------------------------
package core_reset_pkg;

    localparam int unsigned CNT_W             = 16;
    localparam int unsigned DEF_NUM_STAGES    = 4;
    localparam int unsigned DEF_STAGE_DELAY   = 16;
    localparam int unsigned DEF_DRAIN_TIMEOUT = 256;

    localparam logic [CNT_W-1:0] CNT_ZERO = 16'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 16'd1;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    // Decrement that sticks at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_ZERO) begin
            result = CNT_ZERO;
        end else begin
            result = value - CNT_ONE;
        end
        return result;
    endfunction

endpackage

// File: rtl/core_reset_timer.sv
// -----------------------------------------------------------------------------
// core_reset_timer
// Loadable saturating down-counter with a "last cycle" flag.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset, clears the count
//   load     : load load_val on the next edge (wins over dec)
//   load_val : value to load
//   dec      : decrement by one on the next edge (saturates at zero)
//   done     : count currently equals one, i.e. this is the final cycle
// -----------------------------------------------------------------------------
module core_reset_timer
    import core_reset_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: load has priority over decrement.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec) begin
            count_d = sat_dec(count_q);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == CNT_ONE);

endmodule

// File: rtl/core_reset_sequencer.sv
// -----------------------------------------------------------------------------
// core_reset_sequencer
// Releases NUM_STAGES reset domains one after another, STAGE_DELAY cycles
// apart, and handles core soft-reset requests by draining the pipeline
// (bounded by DRAIN_TIMEOUT cycles) before re-running the release sequence.
// Ports:
//   clk            : clock, rising edge
//   reset          : synchronous active-high reset
//   i_soft_req     : level soft-reset request, held until o_soft_ack
//   o_soft_ack     : one-cycle pulse when a soft reset has completed
//   o_quiesce_req  : asks the pipeline to drain
//   i_quiesced     : pipeline is idle (only looked at while draining)
//   o_stage_resetn : per-domain active-low resets, bit 0 released first
//   o_ready        : every stage released, core running
//   o_timeout      : sticky, last drain ended by timeout
// -----------------------------------------------------------------------------
module core_reset_sequencer
    import core_reset_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = DEF_NUM_STAGES,
    parameter int unsigned STAGE_DELAY   = DEF_STAGE_DELAY,
    parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_soft_req,
    output logic                  o_soft_ack,
    output logic                  o_quiesce_req,
    input  logic                  i_quiesced,
    output logic [NUM_STAGES-1:0] o_stage_resetn,
    output logic                  o_ready,
    output logic                  o_timeout
);

    localparam logic [CNT_W-1:0] STAGE_DELAY_C   = CNT_W'(STAGE_DELAY);
    localparam logic [CNT_W-1:0] STAGE_DELAY_M1  = CNT_W'(STAGE_DELAY - 32'd1);
    localparam logic [CNT_W-1:0] DRAIN_TIMEOUT_C = CNT_W'(DRAIN_TIMEOUT);
    // With a one-cycle delay the first stage goes out on the very first
    // HOLD edge, before the stage timer has had a chance to count.
    localparam bit STAGE_DELAY_IS_ONE = (STAGE_DELAY == 32'd1);

    state_e                state_d, state_q;
    logic [NUM_STAGES-1:0] stage_d, stage_q;
    logic [NUM_STAGES-1:0] stage_shift;
    logic                  ready_d, ready_q;
    logic                  ack_d, ack_q;
    logic                  quiesce_d, quiesce_q;
    logic                  timeout_d, timeout_q;
    logic                  armed_d, armed_q;
    logic                  post_drain_d, post_drain_q;

    logic                  stg_load, stg_dec, stg_done;
    logic [CNT_W-1:0]      stg_val;
    logic                  drn_load, drn_dec, drn_done;

    core_reset_timer u_stage_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (stg_load),
        .load_val (stg_val),
        .dec      (stg_dec),
        .done     (stg_done)
    );

    core_reset_timer u_drain_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (drn_load),
        .load_val (DRAIN_TIMEOUT_C),
        .dec      (drn_dec),
        .done     (drn_done)
    );

    // Stage vector with one more low-order domain released.
    always_comb begin
        stage_shift    = stage_q;
        stage_shift[0] = 1'b1;
        for (int i = 1; i < NUM_STAGES; i++) begin
            stage_shift[i] = stage_q[i-1];
        end
    end

    // Next-state, output and timer-control logic.
    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        ready_d      = ready_q;
        ack_d        = 1'b0;
        quiesce_d    = quiesce_q;
        timeout_d    = timeout_q;
        post_drain_d = post_drain_q;
        // Re-arm whenever the request is seen low, in any state.
        armed_d      = i_soft_req ? armed_q : 1'b1;
        stg_load     = 1'b0;
        stg_val      = STAGE_DELAY_C;
        stg_dec      = 1'b0;
        drn_load     = 1'b0;
        drn_dec      = 1'b0;

        case (state_q)
            HOLD, RELEASE: begin
                if ((state_q == HOLD) ? STAGE_DELAY_IS_ONE : stg_done) begin
                    stage_d  = stage_shift;
                    stg_load = 1'b1;
                    stg_val  = STAGE_DELAY_C;
                    if (stage_shift[NUM_STAGES-1]) begin
                        state_d      = RUN;
                        ready_d      = 1'b1;
                        ack_d        = post_drain_q;
                        post_drain_d = 1'b0;
                    end else begin
                        state_d = RELEASE;
                    end
                end else if (state_q == HOLD) begin
                    // The HOLD edge itself is cycle 1 of the first delay.
                    stg_load = 1'b1;
                    stg_val  = STAGE_DELAY_M1;
                    state_d  = RELEASE;
                end else begin
                    stg_dec = 1'b1;
                end
            end
            RUN: begin
                if (i_soft_req && armed_q) begin
                    state_d   = DRAIN;
                    ready_d   = 1'b0;
                    quiesce_d = 1'b1;
                    timeout_d = 1'b0;
                    armed_d   = 1'b0;
                    drn_load  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // A quiesce on the final timeout cycle still counts as clean.
                if (i_quiesced || drn_done) begin
                    state_d      = HOLD;
                    stage_d      = {NUM_STAGES{1'b0}};
                    quiesce_d    = 1'b0;
                    timeout_d    = ~i_quiesced;
                    post_drain_d = 1'b1;
                end else begin
                    drn_dec = 1'b1;
                end
            end
            default: begin
                state_d      = HOLD;
                stage_d      = {NUM_STAGES{1'b0}};
                ready_d      = 1'b0;
                quiesce_d    = 1'b0;
                post_drain_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HOLD;
            stage_q      <= {NUM_STAGES{1'b0}};
            ready_q      <= 1'b0;
            ack_q        <= 1'b0;
            quiesce_q    <= 1'b0;
            timeout_q    <= 1'b0;
            armed_q      <= 1'b1;
            post_drain_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            ready_q      <= ready_d;
            ack_q        <= ack_d;
            quiesce_q    <= quiesce_d;
            timeout_q    <= timeout_d;
            armed_q      <= armed_d;
            post_drain_q <= post_drain_d;
        end
    end

    assign o_stage_resetn = stage_q;
    assign o_ready        = ready_q;
    assign o_soft_ack     = ack_q;
    assign o_quiesce_req  = quiesce_q;
    assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_core_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_reset_sequencer
// Two sequencers share one clock: "a" with default parameters and "b" with
// every parameter at its minimum (1 stage, 1-cycle delay, 1-cycle timeout).
// Cycle n is the n-th rising edge after reset is released; outputs are
// sampled 1 time unit after that edge. Expected values for both instances and
// the input schedule are tables indexed by cycle number.
// Expected vector packing: {stage[3:0], ready, ack, quiesce_req, timeout}.
// -----------------------------------------------------------------------------
module tb_core_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_req, a_quiesced;
    logic       a_ack, a_qreq, a_ready, a_tmo;
    logic [3:0] a_stage;
    logic       b_reset, b_req, b_quiesced;
    logic       b_ack, b_qreq, b_ready, b_tmo;
    logic [0:0] b_stage;

    core_reset_sequencer u_dut_a (
        .clk            (clk),
        .reset          (a_reset),
        .i_soft_req     (a_req),
        .o_soft_ack     (a_ack),
        .o_quiesce_req  (a_qreq),
        .i_quiesced     (a_quiesced),
        .o_stage_resetn (a_stage),
        .o_ready        (a_ready),
        .o_timeout      (a_tmo)
    );

    core_reset_sequencer #(
        .NUM_STAGES    (1),
        .STAGE_DELAY   (1),
        .DRAIN_TIMEOUT (1)
    ) u_dut_b (
        .clk            (clk),
        .reset          (b_reset),
        .i_soft_req     (b_req),
        .o_soft_ack     (b_ack),
        .o_quiesce_req  (b_qreq),
        .i_quiesced     (b_quiesced),
        .o_stage_resetn (b_stage),
        .o_ready        (b_ready),
        .o_timeout      (b_tmo)
    );

    typedef struct {
        int         cyc;
        logic [7:0] v;
        string      name;
    } exp_t;

    typedef struct {
        int   cyc;
        logic a_rst;
        logic a_req;
        logic a_q;
        logic b_req;
        logic b_q;
    } stim_t;

    localparam int LAST_CYC = 700;

    exp_t  qa[$];
    exp_t  qb[$];
    stim_t qs[$];
    int    n_checks   = 0;
    int    n_fail     = 0;
    int    ack_a      = 0;
    int    ack_b      = 0;
    int    contig_err = 0;

    task automatic cmp(input string name, input int cyc, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, exp);
        end
    endtask

    function automatic void ea(input int c, input logic [7:0] v, input string n);
        exp_t e;
        e.cyc = c; e.v = v; e.name = n;
        qa.push_back(e);
    endfunction

    function automatic void eb(input int c, input logic [7:0] v, input string n);
        exp_t e;
        e.cyc = c; e.v = v; e.name = n;
        qb.push_back(e);
    endfunction

    function automatic void st(input int c, input logic ar, input logic aq_req, input logic aq,
                               input logic bq_req, input logic bq);
        stim_t s;
        s.cyc = c; s.a_rst = ar; s.a_req = aq_req; s.a_q = aq; s.b_req = bq_req; s.b_q = bq;
        qs.push_back(s);
    endfunction

    // Ack pulse counters and stage-contiguity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_ack === 1'b1) ack_a <= ack_a + 1;
        if (b_ack === 1'b1) ack_b <= ack_b + 1;
        if (!$isunknown(a_stage) && (((a_stage + 4'd1) & a_stage) != 4'd0))
            contig_err <= contig_err + 1;
    end

    initial begin
        exp_t  e;
        stim_t s;

        a_reset = 1'b1; a_req = 1'b0; a_quiesced = 1'b0;
        b_reset = 1'b1; b_req = 1'b0; b_quiesced = 1'b0;

        // Power-up release, defaults.
        ea(  1, 8'b0000_0_0_0_0, "pwr_c1");
        ea( 15, 8'b0000_0_0_0_0, "pwr_c15");
        ea( 16, 8'b0001_0_0_0_0, "pwr_c16");
        ea( 31, 8'b0001_0_0_0_0, "pwr_c31");
        ea( 32, 8'b0011_0_0_0_0, "pwr_c32");
        ea( 47, 8'b0011_0_0_0_0, "pwr_c47");
        ea( 48, 8'b0111_0_0_0_0, "pwr_c48");
        ea( 63, 8'b0111_0_0_0_0, "pwr_c63");
        ea( 64, 8'b1111_1_0_0_0, "pwr_c64");
        ea( 65, 8'b1111_1_0_0_0, "pwr_c65");
        ea( 70, 8'b1111_1_0_0_0, "pwr_run");
        // Quiesce path: request after 70, quiesced after 80.
        ea( 71, 8'b1111_0_0_1_0, "drq_entry");
        ea( 80, 8'b1111_0_0_1_0, "drq_wait");
        ea( 81, 8'b0000_0_0_0_0, "drq_exit");
        ea( 96, 8'b0000_0_0_0_0, "drq_hold15");
        ea( 97, 8'b0001_0_0_0_0, "drq_s0");
        ea(113, 8'b0011_0_0_0_0, "drq_s1");
        ea(129, 8'b0111_0_0_0_0, "drq_s2");
        ea(144, 8'b0111_0_0_0_0, "drq_pre");
        ea(145, 8'b1111_1_1_0_0, "drq_ack");
        ea(146, 8'b1111_1_0_0_0, "drq_ack_end");
        // Request held high through ack: must not drain again.
        ea(170, 8'b1111_1_0_0_0, "rearm_none");
        // Timeout path: re-request after 172, never quiesced.
        ea(173, 8'b1111_0_0_1_0, "tmo_entry");
        ea(428, 8'b1111_0_0_1_0, "tmo_pre");
        ea(429, 8'b0000_0_0_0_1, "tmo_exit");
        ea(445, 8'b0001_0_0_0_1, "tmo_s0");
        ea(492, 8'b0111_0_0_0_1, "tmo_pre_rdy");
        ea(493, 8'b1111_1_1_0_1, "tmo_ack");
        ea(494, 8'b1111_1_0_0_1, "tmo_ack_end");
        ea(500, 8'b1111_1_0_0_1, "tmo_sticky");
        // Quick drain, then reset while stage 1 is released.
        ea(501, 8'b1111_0_0_1_0, "rr_entry");
        ea(506, 8'b0000_0_0_0_0, "rr_exit");
        ea(522, 8'b0001_0_0_0_0, "rr_s0");
        ea(538, 8'b0011_0_0_0_0, "rr_s1");
        ea(540, 8'b0011_0_0_0_0, "rr_pre_rst");
        ea(541, 8'b0000_0_0_0_0, "rr_reset");
        ea(558, 8'b0001_0_0_0_0, "rr_restart_s0");
        ea(606, 8'b1111_1_0_0_0, "rr_ready_noack");
        // Reset in the middle of a drain.
        ea(611, 8'b1111_0_0_1_0, "rd_entry");
        ea(621, 8'b0000_0_0_0_0, "rd_reset");
        ea(637, 8'b0001_0_0_0_0, "rd_s0");
        ea(684, 8'b0111_0_0_0_0, "rd_pre");
        ea(685, 8'b1111_1_0_0_0, "rd_ready_noack");

        // Minimum-parameter instance.
        eb(  1, 8'b0001_1_0_0_0, "b_ready_c1");
        eb(  5, 8'b0001_1_0_0_0, "b_run");
        eb(  6, 8'b0001_0_0_1_0, "b_tmo_entry");
        eb(  7, 8'b0000_0_0_0_1, "b_tmo_exit");
        eb(  8, 8'b0001_1_1_0_1, "b_tmo_ack");
        eb(  9, 8'b0001_1_0_0_1, "b_tmo_ack_end");
        eb( 11, 8'b0001_0_0_1_0, "b_tie_entry");
        eb( 12, 8'b0000_0_0_0_0, "b_tie_exit");
        eb( 13, 8'b0001_1_1_0_0, "b_tie_ack");
        eb( 14, 8'b0001_1_0_0_0, "b_tie_ack_end");
        eb(700, 8'b0001_1_0_0_0, "b_idle");

        // Input schedule: values driven just after the edge of the given cycle.
        st(  5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        st(  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        st( 10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        st( 13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        st( 70, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        st( 80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        st(150, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        st(170, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        st(172, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        st(494, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        st(500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        st(505, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        st(506, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        st(540, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        st(542, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        st(610, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        st(615, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        st(620, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        st(621, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        cmp("reset_a", 0, {a_stage, a_ready, a_ack, a_qreq, a_tmo}, 8'h00);
        cmp("reset_b", 0, {3'b000, b_stage, b_ready, b_ack, b_qreq, b_tmo}, 8'h00);
        a_reset = 1'b0;
        b_reset = 1'b0;

        for (int c = 1; c <= LAST_CYC; c++) begin
            @(posedge clk);
            #1;
            while (qa.size() > 0 && qa[0].cyc == c) begin
                e = qa.pop_front();
                cmp(e.name, c, {a_stage, a_ready, a_ack, a_qreq, a_tmo}, e.v);
            end
            while (qb.size() > 0 && qb[0].cyc == c) begin
                e = qb.pop_front();
                cmp(e.name, c, {3'b000, b_stage, b_ready, b_ack, b_qreq, b_tmo}, e.v);
            end
            while (qs.size() > 0 && qs[0].cyc == c) begin
                s = qs.pop_front();
                a_reset    = s.a_rst;
                a_req      = s.a_req;
                a_quiesced = s.a_q;
                b_req      = s.b_req;
                b_quiesced = s.b_q;
            end
        end

        cmp("sb_a_left", LAST_CYC, 8'(qa.size()), 8'd0);
        cmp("sb_b_left", LAST_CYC, 8'(qb.size()), 8'd0);
        cmp("ack_count_a", LAST_CYC, 8'(ack_a), 8'd2);
        cmp("ack_count_b", LAST_CYC, 8'(ack_b), 8'd2);
        cmp("stage_contiguous", LAST_CYC, 8'(contig_err), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_reset_sequencer.md
CORE_RESET_SEQUENCER -- requirements
Module: core_reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of reset domains released in order; legal range 1..8.
REQ-002 Parameter STAGE_DELAY, default 16: cycles between successive stage releases; legal range 1..65535.
REQ-003 Parameter DRAIN_TIMEOUT, default 256: maximum cycles to wait for quiesce before forcing reset; legal range 1..65535.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_soft_req  input  1  level request for a core soft reset; requester holds it until o_soft_ack.
REQ-007 o_soft_ack  output  1  one-cycle pulse when a soft reset completes.
REQ-008 o_quiesce_req  output  1  asks the pipeline to drain.
REQ-009 i_quiesced  input  1  pipeline reports it is idle.
REQ-010 o_stage_resetn  output  NUM_STAGES  per-domain active-low reset; bit 0 is released first.
REQ-011 o_ready  output  1  all stages released; core running.
REQ-012 o_timeout  output  1  sticky flag; the last drain ended by timeout.

Function
REQ-013 The FSM SHALL have four states:
- HOLD: all stages held.
- RELEASE: stages being released.
- RUN
- DRAIN
REQ-014 Stage release timing:
- Cycle 1 is the first edge at which reset is sampled low.
- o_stage_resetn[k] SHALL rise at the edge ending cycle (k+1)*STAGE_DELAY.
- o_stage_resetn[k] SHALL stay high thereafter until a reset or drain completes.
REQ-015 o_ready SHALL rise on the same edge as o_stage_resetn[NUM_STAGES-1]. The FSM enters RUN on that edge.
REQ-016 Released stages SHALL form a contiguous low-order run of ones. No higher bit is ever high while a lower bit is low.
REQ-017 An armed flag SHALL work as follows:
- Reset sets it.
- Accepting a soft request clears it.
- Sampling i_soft_req low re-sets it.
REQ-018 Soft request acceptance:
- In RUN, with i_soft_req=1 and armed=1, the next edge SHALL enter DRAIN, drop o_ready and raise o_quiesce_req.
- i_soft_req SHALL be ignored in all other states and while disarmed.
REQ-019 On DRAIN entry, the timeout counter SHALL load DRAIN_TIMEOUT and o_timeout SHALL clear.
REQ-020 In DRAIN, the counter SHALL decrement by one per cycle.
REQ-021 DRAIN SHALL exit on the first edge where i_quiesced=1 or the counter equals 1. If both are true on the same edge, i_quiesced takes priority and o_timeout stays 0.
REQ-022 On DRAIN exit, on the same edge:
- All o_stage_resetn bits SHALL go low.
- o_quiesce_req SHALL go low.
- o_timeout SHALL set if the exit was by timeout.
- The FSM SHALL enter HOLD.
REQ-023 After a drain, release timing SHALL be identical to REQ-014, with cycle 1 being the first cycle in HOLD.
REQ-024 o_soft_ack SHALL pulse high for exactly one cycle, coincident with o_ready rising after a drain. It SHALL never pulse after a plain reset.
REQ-025 Counter width SHALL be 16 bits. Counters SHALL saturate and never wrap.
REQ-026 i_quiesced SHALL be ignored outside DRAIN.

Reset
REQ-027 While reset=1, each edge SHALL set:
- state HOLD
- o_stage_resetn all zero
- o_ready, o_soft_ack, o_quiesce_req, o_timeout all 0
- counters 0
- armed 1
REQ-028 A reset asserted in any state, including mid-RELEASE or mid-DRAIN, SHALL abort the operation. No o_soft_ack SHALL be produced for the aborted request.

Structure
REQ-029 Package core_reset_pkg SHALL hold:
- the state enum (HOLD, RELEASE, RUN, DRAIN)
- the default parameter constants
- the counter width constant (16)
REQ-030 One sub-module, core_reset_timer, SHALL be used: a loadable 16-bit saturating down-counter with a done flag. It SHALL be instanced twice: stage delay and drain timeout.
REQ-031 All outputs SHALL be registered. No combinational input-to-output path is permitted.

Verification
REQ-032 Power-up, defaults. Stimulus: deassert reset at cycle 0. Response: o_stage_resetn = 0001, 0011, 0111, 1111 at cycles 16, 32, 48, 64; o_ready=1 at cycle 64; o_soft_ack never pulses.
REQ-033 Quiesce path. Stimulus: i_soft_req=1 in RUN, i_quiesced=1 after 10 cycles. Response: o_quiesce_req high 10 cycles; all stages low next edge; re-release after 16/32/48/64 cycles; o_soft_ack one pulse with o_ready; o_timeout=0.
REQ-034 Timeout path. Stimulus: i_soft_req=1, i_quiesced held 0. Response: forced reset exactly 256 cycles after DRAIN entry; o_timeout=1, held until the next DRAIN entry.
REQ-035 Re-arm. Stimulus: i_soft_req held high through ack. Response: no second drain; a second drain starts only after i_soft_req goes low, then high again.
REQ-036 Reset mid-operation. Stimulus: reset pulsed during RELEASE (stage 1 released) and during DRAIN. Response: all outputs 0 next edge; release restarts from cycle 1; no o_soft_ack pulse.
REQ-037 Boundaries. Stimulus: NUM_STAGES=1, STAGE_DELAY=1, DRAIN_TIMEOUT=1; also i_quiesced=1 on the timeout edge. Response: o_ready at cycle 1; drain exits after 1 cycle; o_timeout=0 when quiesce coincides with the timeout edge.
